// File: rtl/axi_wdata_order_sched_if.sv
// Bus bundle for the write-path scheduler: requester-side AW/W handshakes,
// initiator-side AW/W handshakes, the external mux selects and status flags.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// in a cycle where both valid and ready are 1 at the rising clock edge; once
// valid is raised it stays up, with its payload stable, until that transfer.
interface axi_wdata_order_sched_if #(
  parameter int N_TARG_PORT = 4,
  parameter int LEN_W       = 8
);
  logic [N_TARG_PORT-1:0]       awvalid_i;
  logic [N_TARG_PORT*LEN_W-1:0] awlen_i;
  logic [N_TARG_PORT-1:0]       awready_o;
  logic                         awvalid_o;
  logic                         awready_i;
  logic [N_TARG_PORT-1:0]       aw_grant_o;
  logic [N_TARG_PORT-1:0]       wvalid_i;
  logic [N_TARG_PORT-1:0]       wlast_i;
  logic [N_TARG_PORT-1:0]       wready_o;
  logic                         wvalid_o;
  logic                         wlast_o;
  logic                         wready_i;
  logic [N_TARG_PORT-1:0]       w_sel_o;
  logic                         wlast_err_o;
  logic                         fifo_full_o;

  // Scheduler side.
  modport slave (
    input  awvalid_i, awlen_i, awready_i, wvalid_i, wlast_i, wready_i,
    output awready_o, awvalid_o, aw_grant_o, wready_o, wvalid_o, wlast_o,
           w_sel_o, wlast_err_o, fifo_full_o
  );

  // Environment side (requesters plus initiator port).
  modport master (
    output awvalid_i, awlen_i, awready_i, wvalid_i, wlast_i, wready_i,
    input  awready_o, awvalid_o, aw_grant_o, wready_o, wvalid_o, wlast_o,
           w_sel_o, wlast_err_o, fifo_full_o
  );
endinterface

// File: rtl/axi_wdata_order_sched.sv
// Write-path scheduler for one initiator port: round-robin AW arbitration,
// an order FIFO of {grant, awlen}, W steering in AW-grant order, and WLAST
// regeneration with a mismatch flag.
module axi_wdata_order_sched #(
  parameter int N_TARG_PORT = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int LEN_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_wdata_order_sched_if.slave  bus
);
  localparam int IDX_W = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Round-robin pick: first requester at or after ptr, wrapping.
  function automatic logic [N_TARG_PORT-1:0] rr_pick(
    input logic [N_TARG_PORT-1:0] req,
    input logic [IDX_W-1:0]       ptr
  );
    logic [N_TARG_PORT-1:0] g;
    logic                   found;
    logic [IDX_W-1:0]       sel;
    int                     idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_TARG_PORT) idx = idx - N_TARG_PORT;
      sel = IDX_W'(idx);
      if (!found && req[sel]) begin
        g[sel] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // State
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic [N_TARG_PORT-1:0] lock_grant_q, lock_grant_d;
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic [N_TARG_PORT-1:0] fifo_grant_q [FIFO_DEPTH];
  logic [N_TARG_PORT-1:0] fifo_grant_d [FIFO_DEPTH];
  logic [LEN_W-1:0]       fifo_len_q   [FIFO_DEPTH];
  logic [LEN_W-1:0]       fifo_len_d   [FIFO_DEPTH];
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  // Combinational nets
  logic [N_TARG_PORT-1:0] aw_grant;
  logic                   aw_valid;
  logic                   aw_hs;
  logic [IDX_W-1:0]       grant_idx;
  logic [LEN_W-1:0]       push_len;
  logic                   full;
  logic                   empty;
  logic [N_TARG_PORT-1:0] head_grant;
  logic [LEN_W-1:0]       head_len;
  logic                   w_valid;
  logic                   w_hs;
  logic                   is_last;
  logic                   pop;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // AW path: frozen grant while locked, otherwise live round-robin; no push when full.
  always_comb begin
    aw_grant  = lock_q ? lock_grant_q : rr_pick(bus.awvalid_i, rr_ptr_q);
    aw_valid  = (|(bus.awvalid_i & aw_grant)) && !full;
    aw_hs     = aw_valid && bus.awready_i;
    grant_idx = '0;
    push_len  = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (aw_grant[i]) begin
        grant_idx = IDX_W'(i);
        push_len  = bus.awlen_i[i*LEN_W +: LEN_W];
      end
    end
  end

  // W path: head entry selects the source; beat count drives WLAST and pop.
  always_comb begin
    head_grant = empty ? '0 : fifo_grant_q[rd_ptr_q[PTR_W-1:0]];
    head_len   = empty ? '0 : fifo_len_q[rd_ptr_q[PTR_W-1:0]];
    w_valid    = |(bus.wvalid_i & head_grant);
    w_hs       = w_valid && bus.wready_i;
    is_last    = (cnt_q == head_len);
    pop        = w_hs && is_last;
  end

  // Next state for arbiter pointer, lock, FIFO, beat counter and error pulse.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_grant_d = lock_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_grant_d = fifo_grant_q;
    fifo_len_d   = fifo_len_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;

    if (aw_hs) begin
      lock_d = 1'b0;
      rr_ptr_d = (grant_idx == IDX_W'(N_TARG_PORT - 1)) ? '0 : grant_idx + 1'b1;
      fifo_grant_d[wr_ptr_q[PTR_W-1:0]] = aw_grant;
      fifo_len_d[wr_ptr_q[PTR_W-1:0]]   = push_len;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (aw_valid) begin
      lock_d       = 1'b1;
      lock_grant_d = aw_grant;
    end

    if (w_hs) begin
      err_d = (|(bus.wlast_i & head_grant)) != is_last;
      if (is_last) begin
        cnt_d    = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register; reset drops all pending bursts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_grant_q[i] <= '0;
        fifo_len_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_grant_q <= lock_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fifo_grant_q <= fifo_grant_d;
      fifo_len_q   <= fifo_len_d;
    end
  end

  // Outputs; AW side is forced low during reset since it follows live inputs.
  always_comb begin
    bus.aw_grant_o  = rst ? '0 : aw_grant;
    bus.awvalid_o   = rst ? 1'b0 : aw_valid;
    bus.awready_o   = rst ? '0 : (aw_grant & {N_TARG_PORT{bus.awready_i && !full}});
    bus.w_sel_o     = head_grant;
    bus.wvalid_o    = w_valid;
    bus.wready_o    = head_grant & {N_TARG_PORT{bus.wready_i}};
    bus.wlast_o     = w_valid && is_last;
    bus.wlast_err_o = err_q;
    bus.fifo_full_o = full;
  end
endmodule
